fir_output_decimator: RTL and testbench
=======================================

# fir_output_decimator

Downstream stage for the FIR filter. It takes the filter's full-precision output every clock and keeps one of every DECIM samples. Each kept sample is rounded and right-shifted to the output width, with saturation. Results are buffered in a small first-word-fall-through (FWFT) FIFO and presented on a valid/ready interface, so a slower consumer can backpressure without stalling the filter.

## Interface
- DATA_IN_WIDTH, 32, width of signed input sample (matches filter output)
- DATA_OUT_WIDTH, 16, width of signed output sample
- SHIFT, 15, arithmetic right shift applied after rounding; must be ≥1
- DECIM, 4, decimation factor; must be ≥1
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2

- clk  input  1  single clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- data_in  input  DATA_IN_WIDTH  signed sample from FIR filter
- in_valid  input  1  data_in is a new sample this cycle (tie high behind the filter)
- out_data  output  DATA_OUT_WIDTH  signed FIFO head sample
- out_valid  output  1  FIFO not empty
- out_ready  input  1  consumer accepts head when out_valid is high
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- sat_flag  output  1  sticky: a kept sample saturated
- drop_flag  output  1  sticky: a kept sample was lost because the FIFO was full
- clear_flags  input  1  synchronous clear of sat_flag and drop_flag

## Operation
- Phase counter counts 0..DECIM-1.
  - It advances only on in_valid and wraps to 0.
  - A sample is kept when in_valid is high and phase is 0. DECIM=1 keeps every valid sample.
- Scaling, computed at DATA_IN_WIDTH+1 bits:
  - r = (data_in + 2^(SHIFT-1)) >>> SHIFT. This is round-half-up toward +inf.
  - If r > 2^(DATA_OUT_WIDTH-1)-1, output the maximum positive value.
  - If r < -2^(DATA_OUT_WIDTH-1), output the minimum negative value.
  - Either saturation case sets sat_flag.
  - Rounding must not overflow, even for data_in = max positive.
- Stage register: holds the scaled sample plus a pending bit, set by a kept sample.
- FIFO: FWFT. out_data shows the head combinationally from storage.
  - Pop when out_valid && out_ready.
  - Write when pending is set and (not full, or a pop happens in the same cycle).
  - If full and no pop, the pending sample is discarded and drop_flag is set.
  - Samples are never reordered.
- Pointers wrap modulo FIFO_DEPTH. fifo_level = writes − pops, range 0..FIFO_DEPTH.
- Flags:
  - clear_flags clears both flags.
  - If a set event and clear_flags occur in the same cycle, the set wins.
- Reset: clears all state regardless of clock.
  - In flight during reset, any pending sample and all FIFO content are lost.
  - phase restarts at 0, so the first valid sample after reset is kept.

## Timing
- Reset values: out_data=0, out_valid=0, fifo_level=0, sat_flag=0, drop_flag=0. Phase=0, pending=0.
- Latency, kept sample at edge k (FIFO empty):
  - Stage register loads at edge k.
  - FIFO write at edge k+1.
  - out_valid=1 and out_data valid in the cycle after edge k+1, i.e. 2 clocks.
- sat_flag asserts after edge k. drop_flag asserts after edge k+1.
- Throughput: one sample per clock when DECIM=1 and out_ready is held high.
- Pop and write in the same cycle when full: level stays FIFO_DEPTH and there is no drop.
- out_ready is ignored while out_valid=0. out_data holds its last head value when empty; its content is don't-care there.

## Test plan
- Reset:
  - Stimulus: assert reset_n=0 mid-stream with the FIFO holding 3 entries.
  - Required: out_valid=0, fifo_level=0, and both flags 0 immediately.
  - Required: the first valid sample after release is kept.
- Rounding, SHIFT=15, DECIM=1:
  - Inputs 32768, 16384, 16383, −16384, −16385 → outputs 1, 1, 0, 0, −1.
  - Each output appears 2 clocks after input; sat_flag stays 0.
- Saturation:
  - Inputs 0x7FFFFFFF, 0x80000000 → outputs 32767, −32768.
  - sat_flag=1; clear_flags=1 → sat_flag=0 next cycle.
- Decimation, DECIM=4:
  - Stimulus: in_valid high, data_in = n·32768 for n=0..15.
  - Required: outputs 0, 4, 8, 12. in_valid low cycles do not advance the phase.
- Backpressure, DECIM=1, FIFO_DEPTH=4:
  - Stimulus: out_ready=0 for 10 valid inputs 1..10 (scaled).
  - Required: fifo_level saturates at 4 and drop_flag=1.
  - Then out_ready=1: outputs 1, 2, 3, 4 in order, then new samples.
- Full with simultaneous pop:
  - Stimulus: FIFO full, out_ready=1 while a kept sample arrives each cycle.
  - Required: level stays 4 and drop_flag stays 0.

Source files
------------

// File: rtl/fir_output_decimator.sv
// ---------------------------------------------------------------------------
// fir_output_decimator
//
// Sits after the FIR filter. It keeps one of every DECIM valid samples,
// rounds the kept sample half-up, shifts it right by SHIFT and saturates it
// to DATA_OUT_WIDTH. Results go through a one-entry stage register into a
// small first-word-fall-through FIFO. A slow consumer can therefore apply
// backpressure without stalling the filter. When the FIFO is full and no pop
// happens, the pending sample is dropped and drop_flag is raised.
//
// Parameters
//   DATA_IN_WIDTH  : width of the signed input sample
//   DATA_OUT_WIDTH : width of the signed output sample
//   SHIFT          : arithmetic right shift after rounding (>= 1)
//   DECIM          : decimation factor (>= 1)
//   FIFO_DEPTH     : output FIFO entries (power of two, >= 2)
//
// Ports
//   clk         : clock; all state changes on the rising edge
//   reset_n     : asynchronous active-low reset
//   data_in     : signed sample from the filter
//   in_valid    : data_in carries a new sample this cycle
//   out_data    : FIFO head, read combinationally from storage
//   out_valid   : FIFO not empty
//   out_ready   : consumer takes the head when out_valid is high
//   fifo_level  : current FIFO occupancy, 0..FIFO_DEPTH
//   sat_flag    : sticky, a kept sample was saturated
//   drop_flag   : sticky, a kept sample was lost on a full FIFO
//   clear_flags : synchronous clear of both sticky flags
// ---------------------------------------------------------------------------
module fir_output_decimator #(
    parameter int DATA_IN_WIDTH  = 32,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int SHIFT          = 15,
    parameter int DECIM          = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic signed [DATA_IN_WIDTH-1:0]  data_in,
    input  logic                             in_valid,
    output logic signed [DATA_OUT_WIDTH-1:0] out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic                             sat_flag,
    output logic                             drop_flag,
    input  logic                             clear_flags
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    // One extra bit so that adding the rounding constant to the largest
    // positive input cannot wrap.
    localparam int SW   = DATA_IN_WIDTH + 1;

    localparam logic signed [SW-1:0] RND_C =
        {{(SW-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [SW-1:0] MAX_C =
        {{(SW-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_C =
        {{(SW-DATA_OUT_WIDTH+1){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};

    // -----------------------------------------------------------------
    // Decimation phase
    // -----------------------------------------------------------------
    logic [PH_W-1:0] phase_q, phase_d;
    logic            keep;

    always_comb begin
        phase_d = phase_q;
        if (in_valid) begin
            if (phase_q == PH_W'(DECIM - 1)) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end
    end

    assign keep = in_valid && (phase_q == '0);

    // -----------------------------------------------------------------
    // Round, shift, saturate
    // -----------------------------------------------------------------
    logic signed [SW-1:0]             ext_in;
    logic signed [SW-1:0]             rounded;
    logic signed [SW-1:0]             shifted;
    logic                             sat_hi;
    logic                             sat_lo;
    logic signed [DATA_OUT_WIDTH-1:0] scaled;

    always_comb begin
        ext_in  = {data_in[DATA_IN_WIDTH-1], data_in};
        rounded = ext_in + RND_C;
        shifted = rounded >>> SHIFT;
        sat_hi  = (shifted > MAX_C);
        sat_lo  = (shifted < MIN_C);
        if (sat_hi) begin
            scaled = MAX_C[DATA_OUT_WIDTH-1:0];
        end else if (sat_lo) begin
            scaled = MIN_C[DATA_OUT_WIDTH-1:0];
        end else begin
            scaled = shifted[DATA_OUT_WIDTH-1:0];
        end
    end

    // -----------------------------------------------------------------
    // Stage register: one kept sample waiting to enter the FIFO. It is
    // consumed on the next edge in every case (written or dropped), so the
    // pending bit simply follows keep.
    // -----------------------------------------------------------------
    logic signed [DATA_OUT_WIDTH-1:0] stage_q, stage_d;
    logic                             pend_q, pend_d;

    always_comb begin
        stage_d = keep ? scaled : stage_q;
        pend_d  = keep;
    end

    // -----------------------------------------------------------------
    // FWFT FIFO
    // -----------------------------------------------------------------
    logic signed [DATA_OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]                    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                    level_q, level_d;
    logic                             full;
    logic                             empty;
    logic                             pop;
    logic                             wr_en;
    logic                             drop_evt;

    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign pop   = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en    = pend_q && (!full || pop);
    assign drop_evt = pend_q && full && !pop;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!wr_en && pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= stage_q;
        end
    end

    // -----------------------------------------------------------------
    // Sticky flags: a set event wins over clear_flags in the same cycle.
    // -----------------------------------------------------------------
    logic sat_q, sat_d;
    logic drop_q, drop_d;

    always_comb begin
        sat_d  = sat_q;
        drop_d = drop_q;
        if (clear_flags) begin
            sat_d  = 1'b0;
            drop_d = 1'b0;
        end
        if (keep && (sat_hi || sat_lo)) begin
            sat_d = 1'b1;
        end
        if (drop_evt) begin
            drop_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q  <= '0;
            stage_q  <= '0;
            pend_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sat_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            stage_q  <= stage_d;
            pend_q   <= pend_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sat_q    <= sat_d;
            drop_q   <= drop_d;
        end
    end

    // -----------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------
    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = !empty;
    assign fifo_level = level_q;
    assign sat_flag   = sat_q;
    assign drop_flag  = drop_q;

endmodule

// File: tb/tb_fir_output_decimator.sv
// ---------------------------------------------------------------------------
// Testbench for fir_output_decimator. Two instances share one stimulus
// stream: index 0 uses DECIM=1 and index 1 uses DECIM=4. Both run with
// SHIFT=15, 32->16 bits and FIFO_DEPTH=4. A queue-based reference model
// predicts every output after every clock. Directed sections add fixed
// expected values for the listed scenarios.
// ---------------------------------------------------------------------------
module tb_fir_output_decimator;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic signed [31:0] data_in;
    logic               in_valid;
    logic               out_ready;
    logic               clear_flags;

    logic signed [15:0] od    [2];
    logic               ov    [2];
    logic [2:0]         lvl   [2];
    logic               satf  [2];
    logic               dropf [2];

    fir_output_decimator #(
        .DATA_IN_WIDTH(32), .DATA_OUT_WIDTH(16), .SHIFT(15),
        .DECIM(1), .FIFO_DEPTH(DEPTH)
    ) u_dec1 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .in_valid(in_valid),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .fifo_level(lvl[0]), .sat_flag(satf[0]), .drop_flag(dropf[0]),
        .clear_flags(clear_flags)
    );

    fir_output_decimator #(
        .DATA_IN_WIDTH(32), .DATA_OUT_WIDTH(16), .SHIFT(15),
        .DECIM(4), .FIFO_DEPTH(DEPTH)
    ) u_dec4 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .in_valid(in_valid),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .fifo_level(lvl[1]), .sat_flag(satf[1]), .drop_flag(dropf[1]),
        .clear_flags(clear_flags)
    );

    int n_err    = 0;
    int n_checks = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int mq [2][$];      // predicted FIFO contents, head at index 0
    int vcount [2];     // valid samples seen since reset
    bit pend_v [2];
    int pend_d [2];
    bit m_sat  [2];
    bit m_drop [2];

    function automatic int dec_of(input int idx);
        return (idx == 0) ? 1 : 4;
    endfunction

    // Round half up, shift by 15, clamp to 16 bits, in 64-bit arithmetic.
    function automatic int scale_ref(input logic signed [31:0] x, output bit sat);
        longint r;
        r   = (longint'(x) + 64'sd16384) >>> 15;
        sat = 1'b0;
        if (r > 32767) begin
            r   = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r   = -32768;
            sat = 1'b1;
        end
        return int'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            vcount[i] = 0;
            pend_v[i] = 1'b0;
            pend_d[i] = 0;
            m_sat[i]  = 1'b0;
            m_drop[i] = 1'b0;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit pop_now, push_now, drop_now, keep_now, sat_now;
            int sv;
            pop_now  = (mq[i].size() != 0) && out_ready;
            push_now = pend_v[i] && ((mq[i].size() < DEPTH) || pop_now);
            drop_now = pend_v[i] && !push_now;
            keep_now = in_valid && ((vcount[i] % dec_of(i)) == 0);
            sv       = scale_ref(data_in, sat_now);
            if (pop_now)  void'(mq[i].pop_front());
            if (push_now) mq[i].push_back(pend_d[i]);
            if (keep_now && sat_now) m_sat[i] = 1'b1;
            else if (clear_flags)    m_sat[i] = 1'b0;
            if (drop_now)            m_drop[i] = 1'b1;
            else if (clear_flags)    m_drop[i] = 1'b0;
            pend_v[i] = keep_now;
            pend_d[i] = sv;
            if (in_valid) vcount[i]++;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            string p;
            p = $sformatf("dec%0d", dec_of(i));
            check({p, " out_valid"}, longint'(ov[i]), longint'(mq[i].size() != 0));
            check({p, " fifo_level"}, longint'(lvl[i]), longint'(mq[i].size()));
            if (mq[i].size() != 0)
                check({p, " out_data"}, longint'(od[i]), longint'(mq[i][0]));
            check({p, " sat_flag"}, longint'(satf[i]), longint'(m_sat[i]));
            check({p, " drop_flag"}, longint'(dropf[i]), longint'(m_drop[i]));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asserts reset away from a clock edge and checks the outputs at once.
    task automatic do_reset();
        in_valid    = 1'b0;
        clear_flags = 1'b0;
        reset_n     = 1'b0;
        #2;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check("reset out_valid", longint'(ov[i]), 0);
            check("reset fifo_level", longint'(lvl[i]), 0);
            check("reset out_data", longint'(od[i]), 0);
            check("reset sat_flag", longint'(satf[i]), 0);
            check("reset drop_flag", longint'(dropf[i]), 0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    int got [$];
    int rin  [5] = '{32768, 16384, 16383, -16384, -16385};
    int rexp [5] = '{1, 1, 0, 0, -1};

    initial begin
        reset_n     = 1'b1;
        data_in     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        clear_flags = 1'b0;
        model_reset();
        #1;
        do_reset();

        // ---- reset mid-stream with three entries held ----
        out_ready = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            in_valid = 1'b1; data_in = n * 32768; step();
        end
        in_valid = 1'b0; step();
        check("midreset level before", longint'(lvl[0]), 3);
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; data_in = 5 * 32768; step();
        in_valid = 1'b0; step();
        check("post-reset first kept valid", longint'(ov[1]), 1);
        check("post-reset first kept data", longint'(od[1]), 5);
        step();

        // ---- rounding, DECIM=1 instance ----
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 5);
            data_in  = (i < 5) ? rin[i] : 0;
            step();
            if (i >= 1 && i <= 5) begin
                check($sformatf("round valid %0d", i - 1), longint'(ov[0]), 1);
                check($sformatf("round data %0d", i - 1), longint'(od[0]), longint'(rexp[i - 1]));
            end
        end
        check("round sat_flag", longint'(satf[0]), 0);

        // ---- saturation and flag clear ----
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; data_in = 32'sh7FFFFFFF; step();
        check("sat flag after edge k", longint'(satf[0]), 1);
        data_in = 32'sh80000000; step();
        check("sat max", longint'(od[0]), 32767);
        in_valid = 1'b0; data_in = 0; step();
        check("sat min", longint'(od[0]), -32768);
        check("sat flag set", longint'(satf[0]), 1);
        clear_flags = 1'b1; step();
        clear_flags = 1'b0;
        check("sat flag cleared", longint'(satf[0]), 0);
        step();

        // ---- decimation with idle gaps, DECIM=4 instance ----
        do_reset();
        out_ready = 1'b1;
        got.delete();
        for (int n = 0; n < 16; n++) begin
            in_valid = 1'b1; data_in = n * 32768; step();
            if (ov[1]) got.push_back(int'(od[1]));
            if (n % 3 == 1) begin
                in_valid = 1'b0; data_in = $urandom; step();
                if (ov[1]) got.push_back(int'(od[1]));
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (ov[1]) got.push_back(int'(od[1]));
        end
        check("decim count", longint'(got.size()), 4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            check($sformatf("decim out %0d", k), longint'(got[k]), longint'(4 * k));

        // ---- backpressure, DECIM=1 instance ----
        do_reset();
        out_ready = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            in_valid = 1'b1; data_in = n * 32768; step();
        end
        in_valid = 1'b0; step();
        check("bp level", longint'(lvl[0]), 4);
        check("bp drop_flag", longint'(dropf[0]), 1);
        out_ready = 1'b1;
        got.delete();
        for (int k = 0; k < 8; k++) begin
            if (ov[0]) got.push_back(int'(od[0]));
            in_valid = (k < 2);
            data_in  = (11 + k) * 32768;
            step();
        end
        check("bp count", longint'(got.size()), 6);
        begin
            int bexp [6] = '{1, 2, 3, 4, 11, 12};
            for (int k = 0; k < 6 && k < got.size(); k++)
                check($sformatf("bp out %0d", k), longint'(got[k]), longint'(bexp[k]));
        end

        // ---- full FIFO with a pop every cycle ----
        do_reset();
        out_ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            in_valid = 1'b1; data_in = n * 32768; step();
        end
        check("full level", longint'(lvl[0]), 4);
        out_ready = 1'b1;
        for (int n = 6; n <= 11; n++) begin
            data_in = n * 32768; step();
            check("full+pop level", longint'(lvl[0]), 4);
            check("full+pop drop", longint'(dropf[0]), 0);
        end
        in_valid = 1'b0;

        // ---- randomized traffic ----
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 1) != 0);
            clear_flags = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 3))
                0: data_in = $urandom;
                1: data_in = $signed($urandom_range(0, 32'h00FFFFFF)) - 32'sh00800000;
                2: data_in = 32'sh3FFF8000 + $signed($urandom_range(0, 32'h0000FFFF)) - 32'sh00008000;
                default: data_in = $signed($urandom_range(0, 32'h0001FFFF)) - 32'sh00010000;
            endcase
            step();
            if ($urandom_range(0, 399) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
